// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Saturating 32-bit add used by the optional performance counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Fetch queue: power-of-two deep FIFO of {pc, instr} entries with a
// synchronous flush that wins over any push/pop in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer/occupancy next state; flush empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks outstanding
// requests against a credit of QDEPTH, queues returning instructions and
// handles core redirects by flushing the queue and discarding in-flight
// responses. Optional macro IFU_PERF_CNT_EN adds perf_fetched/perf_dropped.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int            CW       = $clog2(QDEPTH) + 1;
    localparam logic [CW:0]   QDEPTH_W = (CW + 1)'(QDEPTH);

    ifu_state_e      state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;

    logic            req_fire;
    logic            rsp_dec;
    logic [CW:0]     credit_sum;
    logic [31:0]     rsp_pc;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_head;

    logic            unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Outstanding requests plus queued entries may never exceed the queue
    // depth, so every response is guaranteed a slot when it arrives.
    assign credit_sum     = {1'b0, out_q} + {1'b0, fifo_count};
    assign imem_req_valid = (state_q == ST_RUN) && !fifo_full && (credit_sum < QDEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding would be a stray pre-reset reply; ignore it.
    assign rsp_dec        = imem_rsp_valid && (out_q != '0);

    // In RUN the outstanding requests are contiguous and end just below pc_q,
    // so the oldest one (the one responding now) sits out_q words back.
    assign rsp_pc         = pc_q - (32'(out_q) * 32'(INSTR_BYTES));

    assign fifo_wdata     = '{pc: rsp_pc, instr: imem_rsp_data};
    assign fifo_push      = rsp_dec && (state_q == ST_RUN) && !redirect_valid;
    assign fifo_pop       = fetch_valid && fetch_ready && !redirect_valid;

    ifu_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fetch_valid = !fifo_empty;
    assign fetch_pc    = fetch_valid ? fifo_head.pc    : 32'h0;
    assign fetch_instr = fetch_valid ? fifo_head.instr : 32'h0;

    // Next-state logic: FSM, next-fetch PC and outstanding/drop counter.
    // In FLUSH the outstanding counter doubles as the drop count.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;

        unique case ({req_fire, rsp_dec})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
        end

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid && (out_d != '0)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!redirect_valid && (out_d == '0)) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_dropped_q;
    logic [31:0] drop_inc;

    // Dropped work: responses discarded in FLUSH, or on a redirect in RUN the
    // flushed queue entries plus any response discarded that same cycle.
    always_comb begin
        drop_inc = '0;
        if (state_q == ST_FLUSH) begin
            drop_inc = 32'(rsp_dec);
        end else if ((state_q == ST_RUN) && redirect_valid) begin
            drop_inc = 32'(fifo_count) + 32'(rsp_dec);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= sat_add32(perf_fetched_q, 32'(fifo_pop));
            perf_dropped_q <= sat_add32(perf_dropped_q, drop_inc);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4, fetch queue entries; power of two, >= 2.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  response strobe; in order, one per accepted request, no backpressure, latency >= 1 cycle.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  core-requested PC change (branch/jump).
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 fetch_valid  output  1  queue head holds an instruction for the core.
REQ-013 fetch_ready  input  1  core consumes the head.
REQ-014 fetch_pc  output  32  PC of head instruction.
REQ-015 fetch_instr  output  32  head instruction word.

Function
REQ-016 FSM states BOOT, RUN, FLUSH; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-017 In RUN, imem_req_valid SHALL be 1 iff outstanding + queue occupancy < QDEPTH; in BOOT and FLUSH it SHALL be 0.
REQ-018 On request handshake, the next-fetch PC SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 Each non-dropped response SHALL be written to the queue tail with its request address, visible at the head no earlier than the next cycle.
REQ-020 fetch_valid = queue non-empty; head pops on fetch_valid && fetch_ready; push and pop in the same cycle SHALL both occur.
REQ-021 On redirect_valid: queue flushed, fetch_valid 0 next cycle, next-fetch PC = {redirect_pc[31:2], 2'b00}.
REQ-022 On redirect, drop count = outstanding (including a request handshaking that same cycle, excluding a response arriving that same cycle); if nonzero -> FLUSH, else stay RUN.
REQ-023 In FLUSH, each response SHALL be discarded and decrement drop count; last discard -> RUN next cycle.
REQ-024 Redirect in FLUSH SHALL update next-fetch PC and stay in FLUSH; drop count unchanged.
REQ-025 Redirect SHALL take priority over a simultaneous pop, push or response.
REQ-026 Outstanding counter width clog2(QDEPTH)+1; SHALL never exceed QDEPTH.

Reset
REQ-027 While reset = 0: state BOOT, next-fetch PC = RESET_PC, queue empty, counters 0, imem_req_valid 0, fetch_valid 0, fetch_pc 0, fetch_instr 0.
REQ-028 Assertion mid-operation SHALL clear all state immediately; responses for pre-reset requests are the memory's responsibility to suppress.

Configuration
REQ-029 Macro IFU_PERF_CNT_EN: when defined, adds 32-bit outputs perf_fetched (pops) and perf_dropped (discarded responses plus flushed entries), saturating, reset to 0; when undefined, these ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-030 Shared package ifu_pkg holds state enum, fetch entry struct {pc, instr}, and constant INSTR_BYTES = 4.
REQ-031 Queue SHALL be a sub-module ifu_fifo (parameterised depth, flush input, full/empty/count outputs).

Verification
REQ-032 Reset release, memory latency 1, fetch_ready=1 -> requests 0x0,0x4,0x8,...; first fetch_valid at cycle 3 with fetch_pc 0, fetch_instr = memory word 0.
REQ-033 fetch_ready=0 held -> exactly 4 requests issued, queue full, imem_req_valid 0 until a pop.
REQ-034 Redirect to 0x103 with 2 outstanding -> FLUSH, 2 responses dropped, next request address 0x100, first fetch_pc 0x100.
REQ-035 Redirect with zero outstanding and queue full -> queue empty next cycle, request 0x... target issued the cycle after, no FLUSH.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 With IFU_PERF_CNT_EN, scenario REQ-034 -> perf_dropped = 2 plus flushed entries; perf_fetched = pops observed.
